// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode constants and format tags for the immediate-generation stage.
package imm_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Input/output handshake bundle of imm_gen_stage; master is the fetch/execute side.
interface imm_gen_stage_if
  import imm_pkg::*;
#(
  parameter int unsigned N = 32
);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [N-1:0]  out_imm;
  fmt_e          out_fmt;
  logic          out_illegal;

  modport master (
    output flush, in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RV32/RV64 instruction-to-immediate decoder.
// Optional: IMM_CSR_EN adds the Z format for CSR*I immediates.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [31:0]  instr_i,
  output logic [N-1:0] imm_o,
  output fmt_e         fmt_o,
  output logic         illegal_o
);
  logic [6:0]  opc;
  logic [2:0]  funct3;
  logic [31:0] raw;

  assign opc    = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  always_comb begin
    raw       = '0;
    fmt_o     = FMT_ILL;
    illegal_o = 1'b0;
    unique case (opc)
      OPC_LUI, OPC_AUIPC: begin
        raw   = {instr_i[31:12], 12'b0};
        fmt_o = FMT_U;
      end
      OPC_JAL: begin
        raw   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
        fmt_o = FMT_J;
      end
      OPC_BRANCH: begin
        raw   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
        fmt_o = FMT_B;
      end
      OPC_STORE: begin
        raw   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        fmt_o = FMT_S;
      end
      OPC_LOAD, OPC_JALR: begin
        raw   = {{20{instr_i[31]}}, instr_i[31:20]};
        fmt_o = FMT_I;
      end
      OPC_OPIMM: begin
        fmt_o = FMT_I;
        // Shift amounts exclude funct7 so srai does not leak 0x400 into the immediate.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          raw = (N == 64) ? {26'b0, instr_i[25:20]} : {27'b0, instr_i[24:20]};
        else
          raw = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_SYSTEM: begin
`ifdef IMM_CSR_EN
        if (funct3[2]) begin
          raw   = {27'b0, instr_i[19:15]};
          fmt_o = FMT_Z;
        end else begin
          raw   = {{20{instr_i[31]}}, instr_i[31:20]};
          fmt_o = FMT_I;
        end
`else
        raw   = {{20{instr_i[31]}}, instr_i[31:20]};
        fmt_o = FMT_I;
`endif
      end
      OPC_OP: begin
        raw   = '0;
        fmt_o = FMT_R;
      end
      default: begin
        raw       = '0;
        fmt_o     = FMT_ILL;
        illegal_o = 1'b1;
      end
    endcase
  end

  // Zero-extended forms keep raw[31]=0, so a plain sign extension covers both.
  always_comb begin
    imm_o = '0;
    for (int unsigned i = 0; i < 32; i++)
      imm_o[i] = raw[i];
    for (int unsigned i = 32; i < N; i++)
      imm_o[i] = raw[31];
  end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a DEPTH-entry in-order buffer and flush.
// Optional: IMM_CSR_EN (forwarded to imm_decode) enables the Z format.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  imm_gen_stage_if.slave   bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]  instr;
    logic [N-1:0] imm;
    fmt_e         fmt;
    logic         illegal;
  } entry_t;

  entry_t         ent_q [DEPTH];
  entry_t         ent_d [DEPTH];
  entry_t         new_ent;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  widx;
  logic           accept, pop;
  logic [N-1:0]   dec_imm;
  fmt_e           dec_fmt;
  logic           dec_ill;

  imm_decode #(.N(N)) u_dec (
    .instr_i   (bus.in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  assign new_ent = '{instr: bus.in_instr, imm: dec_imm, fmt: dec_fmt, illegal: dec_ill};

  assign bus.in_ready    = (count_q < CW'(DEPTH));
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_instr   = ent_q[0].instr;
  assign bus.out_imm     = ent_q[0].imm;
  assign bus.out_fmt     = ent_q[0].fmt;
  assign bus.out_illegal = ent_q[0].illegal;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;
  assign widx   = count_q - CW'(pop);

  // Head lives at index 0; a pop shifts the queue down and the new entry lands
  // in the first free slot after that shift, which keeps FIFO order on accept+pop.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++)
          ent_d[i] = ent_q[i + 1];
      end
      if (accept) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          if (CW'(i) == widx)
            ent_d[i] = new_ent;
      end
      count_d = count_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage at N=32 and N=64, DEPTH=2.
module tb_imm_gen_stage;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.N(32)) if32 ();
  imm_gen_stage_if #(.N(64)) if64 ();

  imm_gen_stage #(.N(32), .DEPTH(2)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  imm_gen_stage #(.N(64), .DEPTH(2)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++; if (if32.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b exp 0", if32.out_valid); end
    tests++; if (if32.out_instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp 0", if32.out_instr); end
    tests++; if (if32.out_imm !== 32'h0) begin fails++; $display("FAIL rst_imm got %h exp 0", if32.out_imm); end
    tests++; if (if32.out_fmt !== FMT_R || if32.out_illegal !== 1'b0) begin
      fails++; $display("FAIL rst_fmt got fmt=%0d ill=%0b exp 0/0", if32.out_fmt, if32.out_illegal); end
    tests++; if (if64.out_imm !== 64'h0) begin fails++; $display("FAIL rst_imm64 got %h exp 0", if64.out_imm); end
    rst = 1'b0;
    step();
    tests++; if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
      fails++; $display("FAIL post_rst got rdy=%0b vld=%0b exp 1/0", if32.in_ready, if32.out_valid); end
  endtask

  task automatic test_lui();
    if32.out_ready = 1'b1;
    if32.in_valid  = 1'b1;
    if32.in_instr  = 32'h12345037;
    step();
    if32.in_valid = 1'b0;
    tests++; if (if32.out_valid !== 1'b1 || if32.out_instr !== 32'h12345037) begin
      fails++; $display("FAIL lui_head got vld=%0b instr=%h exp 1/12345037", if32.out_valid, if32.out_instr); end
    tests++; if (if32.out_imm !== 32'h12345000 || if32.out_fmt !== FMT_U) begin
      fails++; $display("FAIL lui_imm got %h fmt=%0d exp 12345000/4", if32.out_imm, if32.out_fmt); end
    step();
    tests++; if (if32.out_valid !== 1'b0) begin fails++; $display("FAIL lui_pop got vld=%0b exp 0", if32.out_valid); end
  endtask

  task automatic test_back_to_back();
    if32.out_ready = 1'b1;
    if32.in_valid  = 1'b1;
    if32.in_instr  = 32'hFE000EE3;
    step();
    if32.in_instr = 32'h001000EF;
    tests++; if (if32.out_imm !== 32'hFFFFFFFC || if32.out_fmt !== FMT_B) begin
      fails++; $display("FAIL beq got %h fmt=%0d exp fffffffc/3", if32.out_imm, if32.out_fmt); end
    step();
    if32.in_instr = 32'hFE20AE23;
    tests++; if (if32.out_imm !== 32'h00000800 || if32.out_fmt !== FMT_J || if32.out_instr !== 32'h001000EF) begin
      fails++; $display("FAIL jal got %h fmt=%0d instr=%h exp 00000800/5/001000ef", if32.out_imm, if32.out_fmt, if32.out_instr); end
    step();
    if32.in_instr = 32'hFFF00093;
    tests++; if (if32.out_imm !== 32'hFFFFFFFC || if32.out_fmt !== FMT_S) begin
      fails++; $display("FAIL sw got %h fmt=%0d exp fffffffc/2", if32.out_imm, if32.out_fmt); end
    step();
    if32.in_instr = 32'h002081B3;
    tests++; if (if32.out_imm !== 32'hFFFFFFFF || if32.out_fmt !== FMT_I) begin
      fails++; $display("FAIL addi got %h fmt=%0d exp ffffffff/1", if32.out_imm, if32.out_fmt); end
    step();
    if32.in_instr = 32'h4030D093;
    tests++; if (if32.out_imm !== 32'h0 || if32.out_fmt !== FMT_R) begin
      fails++; $display("FAIL add got %h fmt=%0d exp 0/0", if32.out_imm, if32.out_fmt); end
    step();
    if32.in_instr = 32'h0000007F;
    tests++; if (if32.out_imm !== 32'h00000003 || if32.out_fmt !== FMT_I) begin
      fails++; $display("FAIL srai got %h fmt=%0d exp 00000003/1", if32.out_imm, if32.out_fmt); end
    step();
    if32.in_instr = 32'h0007D073;
    tests++; if (if32.out_imm !== 32'h0 || if32.out_fmt !== FMT_ILL || if32.out_illegal !== 1'b1 || if32.out_valid !== 1'b1) begin
      fails++; $display("FAIL ill got %h fmt=%0d ill=%0b vld=%0b exp 0/7/1/1", if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_valid); end
    step();
    if32.in_valid = 1'b0;
`ifdef IMM_CSR_EN
    tests++; if (if32.out_imm !== 32'h0000000F || if32.out_fmt !== FMT_Z) begin
      fails++; $display("FAIL csrrwi got %h fmt=%0d exp 0000000f/6", if32.out_imm, if32.out_fmt); end
`else
    tests++; if (if32.out_imm !== 32'h0 || if32.out_fmt !== FMT_I) begin
      fails++; $display("FAIL csrrwi got %h fmt=%0d exp 0/1", if32.out_imm, if32.out_fmt); end
`endif
    step();
    tests++; if (if32.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got vld=%0b exp 0", if32.out_valid); end
  endtask

  task automatic test_xlen64();
    if64.out_ready = 1'b1;
    if64.in_valid  = 1'b1;
    if64.in_instr  = 32'h4030D093;
    step();
    if64.in_instr = 32'h80000037;
    tests++; if (if64.out_imm !== 64'h0000000000000003 || if64.out_fmt !== FMT_I) begin
      fails++; $display("FAIL srai64 got %h fmt=%0d exp 3/1", if64.out_imm, if64.out_fmt); end
    step();
    if64.in_instr = 32'h02109093;
    tests++; if (if64.out_imm !== 64'hFFFFFFFF80000000 || if64.out_fmt !== FMT_U) begin
      fails++; $display("FAIL lui64 got %h fmt=%0d exp ffffffff80000000/4", if64.out_imm, if64.out_fmt); end
    step();
    if64.in_valid = 1'b0;
    tests++; if (if64.out_imm !== 64'h0000000000000021) begin
      fails++; $display("FAIL slli64 got %h exp 21", if64.out_imm); end
    step();
  endtask

  task automatic test_backpressure();
    if32.out_ready = 1'b0;
    if32.in_valid  = 1'b1;
    if32.in_instr  = 32'h11111037;
    step();
    if32.in_instr = 32'h22222037;
    tests++; if (if32.out_instr !== 32'h11111037 || if32.in_ready !== 1'b1) begin
      fails++; $display("FAIL bp_a got %h rdy=%0b exp 11111037/1", if32.out_instr, if32.in_ready); end
    step();
    if32.in_instr = 32'h33333037;
    tests++; if (if32.out_instr !== 32'h11111037 || if32.in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_full got %h rdy=%0b exp 11111037/0", if32.out_instr, if32.in_ready); end
    step();
    step();
    tests++; if (if32.out_instr !== 32'h11111037 || if32.out_imm !== 32'h11111000 || if32.in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_hold got %h imm=%h rdy=%0b exp 11111037/11111000/0", if32.out_instr, if32.out_imm, if32.in_ready); end
    if32.out_ready = 1'b1;
    step();
    tests++; if (if32.out_instr !== 32'h22222037 || if32.in_ready !== 1'b1 || if32.out_valid !== 1'b1) begin
      fails++; $display("FAIL bp_b got %h rdy=%0b vld=%0b exp 22222037/1/1", if32.out_instr, if32.in_ready, if32.out_valid); end
    step();
    if32.in_valid = 1'b0;
    tests++; if (if32.out_instr !== 32'h33333037 || if32.out_imm !== 32'h33333000) begin
      fails++; $display("FAIL bp_c got %h imm=%h exp 33333037/33333000", if32.out_instr, if32.out_imm); end
    step();
    tests++; if (if32.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got vld=%0b exp 0", if32.out_valid); end
  endtask

  task automatic test_flush();
    if32.out_ready = 1'b0;
    if32.in_valid  = 1'b1;
    if32.in_instr  = 32'h44444037;
    step();
    if32.in_instr = 32'h55555037;
    step();
    if32.in_instr = 32'h66666037;
    if32.flush    = 1'b1;
    step();
    if32.flush    = 1'b0;
    if32.in_valid = 1'b0;
    if32.out_ready = 1'b1;
    tests++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_full got vld=%0b rdy=%0b exp 0/1", if32.out_valid, if32.in_ready); end
    step();
    tests++; if (if32.out_valid !== 1'b0) begin fails++; $display("FAIL flush_stay got vld=%0b exp 0", if32.out_valid); end
    if32.out_ready = 1'b0;
    if32.in_valid  = 1'b1;
    if32.in_instr  = 32'h77777037;
    step();
    if32.in_instr  = 32'h88888037;
    if32.out_ready = 1'b1;
    if32.flush     = 1'b1;
    step();
    if32.flush    = 1'b0;
    if32.in_valid = 1'b0;
    tests++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_acc got vld=%0b rdy=%0b exp 0/1", if32.out_valid, if32.in_ready); end
    step();
    step();
    tests++; if (if32.out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop got vld=%0b instr=%h exp 0", if32.out_valid, if32.out_instr); end
    if32.in_valid = 1'b1;
    if32.in_instr = 32'h99999037;
    step();
    if32.in_valid = 1'b0;
    tests++; if (if32.out_valid !== 1'b1 || if32.out_instr !== 32'h99999037) begin
      fails++; $display("FAIL post_flush got vld=%0b instr=%h exp 1/99999037", if32.out_valid, if32.out_instr); end
    step();
  endtask

  initial begin
    if32.flush = 1'b0; if32.in_valid = 1'b0; if32.in_instr = '0; if32.out_ready = 1'b0;
    if64.flush = 1'b0; if64.in_valid = 1'b0; if64.in_instr = '0; if64.out_ready = 1'b0;
    test_reset();
    test_lui();
    test_back_to_back();
    test_xlen64();
    test_backpressure();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, back-pressurable immediate-generation stage for the RV32/RV64 decode path.
- Accepts a raw instruction on a valid/ready handshake and decodes its format from the full 7-bit opcode.
- Produces the sign- or zero-extended N-bit immediate plus a format tag.
- Holds up to two results in an internal skid buffer so fetch and execute can stall independently.
- Supports pipeline flush for branch redirects.

Parameters:
N, 32, immediate/XLEN width; legal values 32 or 64.
DEPTH, 2, output buffer entries; legal values 1 or 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
flush  input  1  discards all buffered entries and any same-cycle input.
in_valid  input  1  in_instr is valid.
in_ready  output  1  stage can accept an instruction this cycle.
in_instr  input  32  raw instruction word.
out_valid  output  1  head entry is valid.
out_ready  input  1  consumer accepts the head entry.
out_instr  output  32  instruction of the head entry.
out_imm  output  N  decoded immediate of the head entry.
out_fmt  output  3  format tag: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, ILL=7.
out_illegal  output  1  asserted when out_fmt==ILL.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset state: count=0. out_valid=0, out_instr=0, out_imm=0, out_fmt=0, out_illegal=0. in_ready=1 from the first cycle after reset.
- Handshakes:
  - Accept: in_valid && in_ready.
  - Pop: out_valid && out_ready.
  - in_ready = (count < DEPTH). It is registered-state based and does not depend combinationally on out_ready.
- Latency: an accepted instruction appears at the outputs on the next cycle when the buffer was empty. Outputs are driven directly from the head entry register.
- Count rules:
  - Accept and pop in the same cycle: count unchanged; FIFO order preserved.
  - Accept only: count+1.
  - Pop only: count-1.
  - When count==DEPTH, no accept is possible.
  - A pop on the same cycle frees space, but in_ready does not rise until the next cycle.
- Head stability: the head entry stays stable while out_valid && !out_ready.
- Flush: next cycle count=0 and out_valid=0. A same-cycle accept is dropped and a same-cycle pop is ignored.
- rst has priority over flush.
- Decode is performed at accept, and decoded fields are stored in the buffer. Decode by opcode[6:0]:
  - U (0110111, 0010111): imm = {instr[31:12], 12'b0}, sign-extended to N.
  - J (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - B (1100011): imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - S (0100011): imm = sext({instr[31:25], instr[11:7]}).
  - I (0000011, 1100111, 0010011, 1110011): imm = sext(instr[31:20]).
    - Exception, OP-IMM shifts (funct3 001/101): imm = zero-extended shamt, instr[24:20] when N=32 or instr[25:20] when N=64. funct7 bits are excluded.
  - R (0110011): imm = 0.
  - Any other opcode: fmt ILL, imm = 0, illegal = 1. The entry still flows through the stage and is never dropped.
- B and J immediates are byte offsets with bit0 = 0.

Optional Feature:
IMM_CSR_EN
- Defined: SYSTEM opcode with funct3[2]==1 (CSRRWI/CSRRSI/CSRRCI) yields fmt Z and imm = zero-extended instr[19:15].
- Undefined: all SYSTEM instructions decode as I, and the fmt value 6 is never produced.

Decomposition:
- Package imm_pkg holds:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM);
  - FMT_* tag constants;
  - the 3-bit format typedef.
- Sub-module imm_decode: purely combinational instruction-to-{imm, fmt, illegal} decoder, parameterised by N. It is instantiated once at the input.
- imm_gen_stage contains the DEPTH-entry buffer, count, and handshake/flush control.

Test Plan:
- Accept 0x12345037 (LUI) with out_ready=1 -> the next cycle shows out_valid=1, imm=0x12345000, fmt=U.
- Send 0xFE000EE3 (beq -4) -> imm=0xFFFFFFFC, fmt=B. Then send 0x001000EF (jal x1, 2048) -> imm=0x00000800, fmt=J.
- Send 0x4030D093 (srai x1, x1, 3) -> imm=0x00000003, not 0x403. At N=64, check imm is 0x0000000000000003.
- Hold out_ready=0 and offer A, B, C -> A and B are accepted, in_ready=0 and C is held. Release out_ready -> A, B, C emerge in order, one per cycle, with no loss or duplication.
- Fill the buffer with 2 entries and assert flush along with a valid input -> the next cycle shows out_valid=0, in_ready=1, and the flushed input never appears.
- Send 0x0000007F -> fmt=ILL, imm=0, out_illegal=1. With IMM_CSR_EN defined, send 0x0007D073 (csrrwi x0, 0, 15) -> fmt=Z, imm=0xF.
